// File: rtl/dot4x_clk_pkg.sv
// -----------------------------------------------------------------------------
// dot4x_clk_pkg
// Shared definitions for the dot4x clock supervisor:
//   - state_t     : supervisor FSM state encoding (3 bits)
//   - DEF_*       : default timing constants for 12 MHz boards
//   - sat_inc8    : saturating 8-bit increment used by the lock-loss counter
// -----------------------------------------------------------------------------
package dot4x_clk_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    // Defaults at 12 MHz: 1 us reset pulse, 100 us lock window.
    localparam int DEF_RESET_CYCLES  = 12;
    localparam int DEF_LOCK_TIMEOUT  = 1200;
    localparam int DEF_SETTLE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int DEF_CNT_W         = 16;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot4x_clock_supervisor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   i_clk   in  destination clock
//   i_rst_n in  async active-low reset, output forced to 0
//   i_d     in  asynchronous input
//   o_q     out synchronized input, 2 i_clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dot4x_clock_supervisor.sv
// -----------------------------------------------------------------------------
// dot4x_clock_supervisor
// Drives the MMCM reset and watches its LOCKED output from the free-running
// 12 MHz board clock. Sequence: reset pulse -> wait for lock -> settle window
// -> run. Lock timeouts and settle glitches retry; after MAX_RETRIES retries
// the supervisor parks in FAULT until retry_req or reset_n.
// Ports:
//   clk_in12mhz   in   board clock, sole clock of this block
//   reset_n       in   async active-low reset
//   locked        in   MMCM LOCKED, asynchronous
//   retry_req     in   1-cycle pulse, only acted upon in FAULT
//   pll_reset     out  active-high MMCM reset
//   clk_ok        out  dot4x clock is stable
//   fault         out  lock not achieved within the retry budget
//   retries       out  [3:0] attempts consumed in the current episode
//   lock_loss_cnt out  [7:0] lock drops seen in RUN, saturating
// -----------------------------------------------------------------------------
module dot4x_clock_supervisor
    import dot4x_clk_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk_in12mhz,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       retry_req,
    output logic       pll_reset,
    output logic       clk_ok,
    output logic       fault,
    output logic [3:0] retries,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    logic             w_locked_s;
    logic             w_budget_spent;
    state_t           w_state_nxt;
    logic [3:0]       w_retries_nxt;
    logic [7:0]       w_loss_nxt;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_reset;
    logic             r_clk_ok;
    logic             r_fault;
    logic [3:0]       r_retries;
    logic [7:0]       r_lock_loss;

    sync_2ff u_sync_locked (
        .i_clk   (clk_in12mhz),
        .i_rst_n (reset_n),
        .i_d     (locked),
        .o_q     (w_locked_s)
    );

    assign w_budget_spent = (r_retries == RETRY_MAX);

    // Next-state decision; a failed attempt (timeout or settle glitch) either
    // retries with a fresh reset pulse or gives up into FAULT.
    always_comb begin
        w_state_nxt   = r_state;
        w_retries_nxt = r_retries;
        w_loss_nxt    = r_lock_loss;
        case (r_state)
            ST_ASSERT_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else begin
                    w_state_nxt = ST_ASSERT_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_SETTLE;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt   = w_budget_spent ? ST_FAULT : ST_ASSERT_RST;
                    w_retries_nxt = w_budget_spent ? r_retries : (r_retries + 4'd1);
                end else begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_SETTLE: begin
                if (!w_locked_s) begin
                    w_state_nxt   = w_budget_spent ? ST_FAULT : ST_ASSERT_RST;
                    w_retries_nxt = w_budget_spent ? r_retries : (r_retries + 4'd1);
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_retries_nxt = 4'd0;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_ASSERT_RST;
                    w_loss_nxt  = sat_inc8(r_lock_loss);
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (retry_req) begin
                    w_state_nxt   = ST_ASSERT_RST;
                    w_retries_nxt = 4'd0;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            default: begin
                w_state_nxt   = ST_ASSERT_RST;
                w_retries_nxt = 4'd0;
            end
        endcase
    end

    // State, phase counter and outputs; outputs are decoded from the next
    // state so they change on the same edge as the transition.
    always_ff @(posedge clk_in12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ASSERT_RST;
            r_cnt       <= {CNT_W{1'b0}};
            r_pll_reset <= 1'b1;
            r_clk_ok    <= 1'b0;
            r_fault     <= 1'b0;
            r_retries   <= 4'd0;
            r_lock_loss <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_retries   <= w_retries_nxt;
            r_lock_loss <= w_loss_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if ((r_state == ST_RUN) || (r_state == ST_FAULT)) begin
                // Unbounded states: hold the counter so it can never wrap.
                r_cnt <= r_cnt;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            r_pll_reset <= (w_state_nxt == ST_ASSERT_RST) || (w_state_nxt == ST_FAULT);
            r_clk_ok    <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_reset     = r_pll_reset;
    assign clk_ok        = r_clk_ok;
    assign fault         = r_fault;
    assign retries       = r_retries;
    assign lock_loss_cnt = r_lock_loss;

endmodule
